// File: rtl/jump_unit_pkg.sv
// Shared types and constants for the decode-stage jump unit.
package jump_unit_pkg;

   // Jump unit FSM: pending redirect and pending delay slot tracked together.
   typedef enum logic [1:0] {
      JU_IDLE     = 2'd0,  // no jump in flight
      JU_REDIR_DS = 2'd1,  // redirect pending, delay slot not yet consumed
      JU_REDIR    = 2'd2,  // redirect pending, delay slot consumed
      JU_DSLOT    = 2'd3   // redirect taken, delay slot still to come
   } ju_state_e;

   // Register written by jal.
   localparam logic [4:0]  JU_LINK_REG    = 5'd31;
   // Link address is the instruction after the delay slot.
   localparam logic [31:0] JU_LINK_OFFSET = 32'd8;

endpackage : jump_unit_pkg

// File: rtl/jump_target_calc.sv
// Combinational jump target select plus target alignment check.
module jump_target_calc (
   input  logic [29:0] pc_word_i,      // id_pc[31:2]
   input  logic [25:0] instr_index_i,
   input  logic [31:0] rs_val_i,
   input  logic        to_rs_i,
   output logic [31:0] target_o,
   output logic        misaligned_o
);

   logic [3:0] region;

   // Region bits come from PC+4: the +4 carries into bit 28 only when PC[27:2] is all ones.
   always_comb begin
      region       = pc_word_i[29:26] + {3'b000, &pc_word_i[25:0]};
      target_o     = to_rs_i ? rs_val_i : {region, instr_index_i, 2'b00};
      misaligned_o = to_rs_i & (rs_val_i[1:0] != 2'b00);
   end

endmodule : jump_target_calc

// File: rtl/jump_unit.sv
// Decode-stage jump unit: target resolution, held redirect handshake to fetch,
// link write-back and branch delay slot tracking.
module jump_unit
   import jump_unit_pkg::*;
#(
   parameter logic [4:0]  LINK_REG    = JU_LINK_REG,
   parameter logic [31:0] LINK_OFFSET = JU_LINK_OFFSET
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic        id_stall,
   input  logic        flush,
   input  logic [31:0] id_pc,
   input  logic [25:0] id_instr_index,
   input  logic        id_is_jump,
   input  logic        jsave,
   input  logic        save_in_rd,
   input  logic        jump_to_rs_val,
   input  logic [31:0] id_rs_val,
   input  logic [4:0]  id_rd,
   input  logic        redirect_ready,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        link_we,
   output logic [4:0]  link_waddr,
   output logic [31:0] link_wdata,
   output logic        in_delay_slot,
   output logic        adel,
   output logic [31:0] adel_badvaddr
);

   ju_state_e   state_q, state_d;

   logic        acc;
   logic        start_jump;
   logic        redirect_start;
   logic        link_fire;
   logic        adel_fire;
   logic [4:0]  waddr_sel;
   logic [31:0] target;
   logic        misaligned;

   logic [31:0] redirect_pc_q;
   logic        link_we_q;
   logic [4:0]  link_waddr_q;
   logic [31:0] link_wdata_q;
   logic        adel_q;
   logic [31:0] adel_badvaddr_q;

   jump_target_calc u_target_calc (
      .pc_word_i     (id_pc[31:2]),
      .instr_index_i (id_instr_index),
      .rs_val_i      (id_rs_val),
      .to_rs_i       (jump_to_rs_val),
      .target_o      (target),
      .misaligned_o  (misaligned)
   );

   // Accept qualification; a jump seen outside IDLE is only a delay slot.
   always_comb begin
      acc            = id_valid & ~id_stall & ~flush;
      start_jump     = acc & id_is_jump & (state_q == JU_IDLE);
      redirect_start = start_jump & ~misaligned;
      waddr_sel      = save_in_rd ? id_rd : LINK_REG;
      link_fire      = redirect_start & jsave & (waddr_sel != 5'd0);
      adel_fire      = start_jump & misaligned;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= JU_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; flush overrides everything, stall only blocks acc.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = JU_IDLE;
      end else begin
         case (state_q)
            JU_IDLE: begin
               if (redirect_start) state_d = JU_REDIR_DS;
            end
            JU_REDIR_DS: begin
               if (redirect_ready && acc)  state_d = JU_IDLE;
               else if (redirect_ready)    state_d = JU_DSLOT;
               else if (acc)               state_d = JU_REDIR;
            end
            JU_REDIR: begin
               if (redirect_ready) state_d = JU_IDLE;
            end
            JU_DSLOT: begin
               if (acc) state_d = JU_IDLE;
            end
            default: state_d = JU_IDLE;
         endcase
      end
   end

   // FSM outputs decoded from state.
   always_comb begin
      redirect_valid = (state_q == JU_REDIR_DS) || (state_q == JU_REDIR);
      in_delay_slot  = (state_q == JU_REDIR_DS) || (state_q == JU_DSLOT);
   end

   // Redirect target is latched only when leaving IDLE, so it holds while valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_pc_q <= 32'd0;
      end else if (redirect_start) begin
         redirect_pc_q <= target;
      end
   end

   // One-cycle link write and address-error pulses, plus their payloads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         link_we_q       <= 1'b0;
         link_waddr_q    <= 5'd0;
         link_wdata_q    <= 32'd0;
         adel_q          <= 1'b0;
         adel_badvaddr_q <= 32'd0;
      end else begin
         link_we_q <= link_fire;
         adel_q    <= adel_fire;
         if (link_fire) begin
            link_waddr_q <= waddr_sel;
            link_wdata_q <= id_pc + LINK_OFFSET;
         end
         if (adel_fire) begin
            adel_badvaddr_q <= id_rs_val;
         end
      end
   end

   // A flush in the cycle a pulse is presented kills it.
   always_comb begin
      redirect_pc   = redirect_pc_q;
      link_we       = link_we_q & ~flush;
      link_waddr    = link_waddr_q;
      link_wdata    = link_wdata_q;
      adel          = adel_q & ~flush;
      adel_badvaddr = adel_badvaddr_q;
   end

endmodule : jump_unit
